// File: rtl/clock_text_pkg.sv
// -----------------------------------------------------------------------------
// clock_text_pkg
// Shared constants and types for the "HH:MM:SS" text pixel generator.
//   GLYPH_DIGIT_BASE / GLYPH_COLON : font ROM character codes
//   SCALE_SHIFT                    : log2 of the glyph magnification (4x)
//   NUM_CHARS, REGION_W, REGION_H  : text region geometry in characters/pixels
// -----------------------------------------------------------------------------
package clock_text_pkg;

    localparam logic [6:0] GLYPH_DIGIT_BASE = 7'h30;
    localparam logic [6:0] GLYPH_COLON      = 7'h3A;
    localparam int         SCALE_SHIFT      = 2;
    localparam int         NUM_CHARS        = 8;
    localparam int         REGION_W         = 256;
    localparam int         REGION_H         = 64;

    // Time digits as captured once per frame.
    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_o;
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } time_bcd_t;

    // Character cells left to right.
    typedef enum logic [2:0] {
        CH_HR_T   = 3'd0,
        CH_HR_O   = 3'd1,
        CH_COLON0 = 3'd2,
        CH_MIN_T  = 3'd3,
        CH_MIN_O  = 3'd4,
        CH_COLON1 = 3'd5,
        CH_SEC_T  = 3'd6,
        CH_SEC_O  = 3'd7
    } char_slot_e;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        return GLYPH_DIGIT_BASE + {3'b000, d};
    endfunction

endpackage

// File: rtl/clock_colon_blink.sv
// -----------------------------------------------------------------------------
// clock_colon_blink
// Counts frames and toggles colon_on every BLINK_FRAMES frames.
// Ports:
//   clk        in   pixel clock
//   reset      in   asynchronous active-high reset
//   frame_tick in   one-cycle pulse at start of each frame
//   colon_on   out  high while colons are to be drawn (1 after reset)
// -----------------------------------------------------------------------------
module clock_colon_blink #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    output logic colon_on
);

    localparam logic [5:0] LAST = 6'(BLINK_FRAMES - 1);

    logic [5:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            colon_on <= 1'b1;
        end else if (frame_tick) begin
            if (cnt == LAST) begin
                cnt      <= '0;
                colon_on <= ~colon_on;
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/clock_text_gen.sv
// -----------------------------------------------------------------------------
// clock_text_gen
// Renders "HH:MM:SS" into a 256x64 region at (X0,Y0) using an 8x16 font ROM
// with 4x scaling. Digits are captured on frame_tick so a frame never tears.
// Pixel latency x/y -> rgb is 2 cycles (ROM register + rgb register); the
// caller must delay hsync/vsync by the same amount.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   video_on                    visible-area flag
//   frame_tick                  start-of-frame pulse (digit latch / blink)
//   x, y                        current pixel coordinates
//   hr_t..sec_o                 BCD time digits
//   rom_addr                    {code[6:0], glyph_row[3:0]}, combinational
//   rom_data                    glyph row, valid one cycle after rom_addr
//   rgb                         registered pixel colour
//
// Build option: define CLOCK_COLON_BLINK_EN to blink the colons every
// BLINK_FRAMES frames; otherwise colons are always drawn.
// -----------------------------------------------------------------------------
module clock_text_gen
    import clock_text_pkg::*;
#(
    parameter int          X0           = 192,
    parameter int          Y0           = 208,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  hr_t,
    input  logic [3:0]  hr_o,
    input  logic [3:0]  min_t,
    input  logic [3:0]  min_o,
    input  logic [3:0]  sec_t,
    input  logic [3:0]  sec_o,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [11:0] rgb
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + REGION_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + REGION_H);

    // ---------------- colon blink ----------------
    logic colon_on;

`ifdef CLOCK_COLON_BLINK_EN
    clock_colon_blink #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .colon_on   (colon_on)
    );
`else
    logic [5:0] unused_blink_frames;
    assign unused_blink_frames = 6'(BLINK_FRAMES);
    assign colon_on = 1'b1;
`endif

    // ---------------- digit latch ----------------
    time_bcd_t digits_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digits_q <= '0;
        else if (frame_tick)
            digits_q <= {hr_t, hr_o, min_t, min_o, sec_t, sec_o};
    end

    // ---------------- region decode ----------------
    logic       in_region;
    logic [7:0] dx;
    logic [5:0] dy;
    logic [2:0] glyph_col;
    logic [3:0] glyph_row;
    char_slot_e slot;

    assign in_region = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                       ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

    // Only the low bits of the offsets matter inside the region, so the
    // subtraction is done at that width directly.
    assign dx        = x[7:0] - 8'(X0);
    assign dy        = y[5:0] - 6'(Y0);
    assign slot      = char_slot_e'(dx[7:5]);
    assign glyph_col = dx[SCALE_SHIFT +: 3];
    assign glyph_row = dy[SCALE_SHIFT +: 4];

    logic [3:0] unused_sub;
    assign unused_sub = {dx[1:0], dy[1:0]};

    // ---------------- character select ----------------
    logic [3:0] digit;
    logic       is_colon;
    logic [6:0] code;
    logic       blank;

    always_comb begin
        digit    = 4'd0;
        is_colon = 1'b0;
        case (slot)
            CH_HR_T:   digit = digits_q.hr_t;
            CH_HR_O:   digit = digits_q.hr_o;
            CH_MIN_T:  digit = digits_q.min_t;
            CH_MIN_O:  digit = digits_q.min_o;
            CH_SEC_T:  digit = digits_q.sec_t;
            CH_SEC_O:  digit = digits_q.sec_o;
            default:   is_colon = 1'b1;
        endcase
    end

    assign code  = is_colon ? GLYPH_COLON : digit_code(digit);
    // A non-BCD digit blanks its whole cell; colons blank while blinked off.
    assign blank = is_colon ? ~colon_on : (digit > 4'd9);

    assign rom_addr = in_region ? {code, glyph_row} : {GLYPH_DIGIT_BASE, 4'h0};

    // ---------------- align with ROM output ----------------
    logic [2:0] col_d;
    logic       in_region_d;
    logic       blank_d;
    logic       video_on_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_d       <= '0;
            in_region_d <= 1'b0;
            blank_d     <= 1'b0;
            video_on_d  <= 1'b0;
        end else begin
            col_d       <= glyph_col;
            in_region_d <= in_region;
            blank_d     <= blank;
            video_on_d  <= video_on;
        end
    end

    // Column 0 is the leftmost pixel, held in the ROM byte's MSB.
    logic pixel;
    assign pixel = rom_data[3'd7 - col_d];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb <= 12'h000;
        else if (!video_on_d)
            rgb <= 12'h000;
        else if (in_region_d && pixel && !blank_d)
            rgb <= FG;
        else
            rgb <= BG;
    end

endmodule

// File: tb/tb_clock_text_gen.sv
module tb_clock_text_gen;

    localparam int          X0 = 192;
    localparam int          Y0 = 208;
    localparam logic [11:0] FG = 12'hFF0;
    localparam logic [11:0] BG = 12'h00F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [3:0]  hr_t = '0, hr_o = '0, min_t = '0, min_o = '0, sec_t = '0, sec_o = '0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [11:0] rgb;

    int total = 0;
    int bad   = 0;

    clock_text_gen #(
        .X0(X0), .Y0(Y0), .FG(FG), .BG(BG), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
        .x(x), .y(y),
        .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Font ROM stand-in: row 2 of '1' = 00011000, colon rows solid,
    // every other row 11110001 (cols 0-3 and 7 set).
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        if (a == 11'h312)         return 8'h18;
        else if (a[10:4] == 7'h3A) return 8'hFF;
        else                      return 8'hF1;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
        hr_t = a; hr_o = b; min_t = c; min_o = d; sec_t = e; sec_o = f;
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    // Hold one pixel long enough for its rgb to emerge.
    task automatic hold_px(input logic [9:0] px, input logic [9:0] py, input logic von);
        x = px; y = py; video_on = von;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_digits(9, 8, 7, 6, 5, 4);
        tick_frame();
        hold_px(10'(X0), 10'(Y0), 1'b1);
        total++; if (rom_addr !== 11'h390) begin bad++; $display("FAIL pre_reset_addr got=%h want=%h", rom_addr, 11'h390); end
        // reset mid-frame
        reset = 1'b1;
        hold_px(10'(X0), 10'(Y0), 1'b1);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL rgb_in_reset got=%h want=%h", rgb, 12'h000); end
        reset = 1'b0;
        set_digits(1, 2, 3, 4, 5, 6);
        @(posedge clk); #1;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL rgb_after_reset got=%h want=%h", rgb, 12'h000); end
        @(posedge clk); #1;
        total++; if (rgb !== FG) begin bad++; $display("FAIL rgb_zero_glyph got=%h want=%h", rgb, FG); end
        total++; if (rom_addr !== 11'h300) begin bad++; $display("FAIL reset_addr_hr got=%h want=%h", rom_addr, 11'h300); end
        hold_px(10'(X0 + 96), 10'(Y0 + 4), 1'b1);
        total++; if (rom_addr !== 11'h301) begin bad++; $display("FAIL reset_addr_min got=%h want=%h", rom_addr, 11'h301); end
        hold_px(10'(X0 + 64), 10'(Y0), 1'b1);
        total++; if (rom_addr !== 11'h3A0) begin bad++; $display("FAIL colon_addr got=%h want=%h", rom_addr, 11'h3A0); end
        hold_px(10'(X0 + 224), 10'(Y0 + 60), 1'b1);
        total++; if (rom_addr !== 11'h30F) begin bad++; $display("FAIL reset_addr_sec got=%h want=%h", rom_addr, 11'h30F); end
    endtask

    task automatic test_scan();
        logic [11:0] want;
        set_digits(1, 2, 3, 4, 5, 6);
        x = '0; y = '0;
        tick_frame();
        y = 10'(Y0 + 8); video_on = 1'b1;
        for (int j = 0; j < 34; j++) begin
            if (j >= 2) begin
                want = ((j - 2) >= 12 && (j - 2) <= 19) ? FG : BG;
                total++; if (rgb !== want) begin bad++; $display("FAIL scan_rgb dx=%0d got=%h want=%h", j - 2, rgb, want); end
            end
            if (j < 32) begin
                x = 10'(X0 + j);
                #1;
                total++; if (rom_addr !== 11'h312) begin bad++; $display("FAIL scan_addr dx=%0d got=%h want=%h", j, rom_addr, 11'h312); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_digit_change();
        sec_o = 4'd7;
        hold_px(10'(X0 + 224), 10'(Y0), 1'b1);
        total++; if (rom_addr !== 11'h360) begin bad++; $display("FAIL no_tear_addr got=%h want=%h", rom_addr, 11'h360); end
        total++; if (rgb !== FG) begin bad++; $display("FAIL no_tear_rgb got=%h want=%h", rgb, FG); end
        tick_frame();
        total++; if (rom_addr !== 11'h370) begin bad++; $display("FAIL new_frame_addr got=%h want=%h", rom_addr, 11'h370); end
        sec_o = 4'd8;
        tick_frame();
        total++; if (rom_addr !== 11'h380) begin bad++; $display("FAIL same_cycle_latch got=%h want=%h", rom_addr, 11'h380); end
    endtask

    task automatic test_blank();
        sec_o = 4'hC;
        tick_frame();
        hold_px(10'(X0 + 224), 10'(Y0), 1'b1);
        total++; if (rgb !== BG) begin bad++; $display("FAIL blank_col0 got=%h want=%h", rgb, BG); end
        hold_px(10'(X0 + 255), 10'(Y0 + 63), 1'b1);
        total++; if (rgb !== BG) begin bad++; $display("FAIL blank_corner got=%h want=%h", rgb, BG); end
        hold_px(10'(X0 + 192), 10'(Y0), 1'b1);
        total++; if (rom_addr !== 11'h350) begin bad++; $display("FAIL blank_neighbor_addr got=%h want=%h", rom_addr, 11'h350); end
        total++; if (rgb !== FG) begin bad++; $display("FAIL blank_neighbor_rgb got=%h want=%h", rgb, FG); end
        sec_o = 4'd6;
        tick_frame();
    endtask

    task automatic test_boundary();
        hold_px(10'(X0 + 255), 10'(Y0), 1'b1);
        total++; if (rgb !== FG) begin bad++; $display("FAIL right_edge_in got=%h want=%h", rgb, FG); end
        hold_px(10'(X0 + 256), 10'(Y0), 1'b1);
        total++; if (rgb !== BG) begin bad++; $display("FAIL right_edge_out got=%h want=%h", rgb, BG); end
        total++; if (rom_addr !== 11'h300) begin bad++; $display("FAIL outside_addr got=%h want=%h", rom_addr, 11'h300); end
        hold_px(10'(X0), 10'(Y0 + 63), 1'b1);
        total++; if (rgb !== FG) begin bad++; $display("FAIL bottom_edge_in got=%h want=%h", rgb, FG); end
        hold_px(10'(X0), 10'(Y0 + 64), 1'b1);
        total++; if (rgb !== BG) begin bad++; $display("FAIL bottom_edge_out got=%h want=%h", rgb, BG); end
        hold_px(10'(X0 - 1), 10'(Y0), 1'b1);
        total++; if (rgb !== BG) begin bad++; $display("FAIL left_edge_out got=%h want=%h", rgb, BG); end
        hold_px(10'(X0), 10'(Y0), 1'b0);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL video_off got=%h want=%h", rgb, 12'h000); end
    endtask

    task automatic test_blink();
        logic [11:0] want;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int f = 0; f < 6; f++) begin
`ifdef CLOCK_COLON_BLINK_EN
            want = (f == 2 || f == 3) ? BG : FG;
`else
            want = FG;
`endif
            hold_px(10'(X0 + 64), 10'(Y0), 1'b1);
            total++; if (rgb !== want) begin bad++; $display("FAIL colon_frame%0d got=%h want=%h", f, rgb, want); end
            hold_px(10'(X0 + 160), 10'(Y0 + 32), 1'b1);
            total++; if (rgb !== want) begin bad++; $display("FAIL colon2_frame%0d got=%h want=%h", f, rgb, want); end
            tick_frame();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_scan();
        test_digit_change();
        test_blank();
        test_boundary();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
